// File: rtl/serial_divisibility_scheduler.sv
// serial_divisibility_scheduler
//   Shares one bit-serial modulo-DIV remainder engine between two requesters.
//   A W-bit word is granted round-robin, shifted MSB-first into the remainder
//   recurrence one bit per clock, and the result is handed out on a
//   valid/ready channel tagged with the issuing requester id.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   req0_valid/data/ready     requester 0 word channel
//   req1_valid/data/ready     requester 1 word channel
//   res_valid/ready           result channel handshake
//   res_id                    requester that issued the word
//   res_div                   1 when word % DIV == 0
//   res_rem                   word % DIV
module serial_divisibility_scheduler #(
  parameter  int W   = 16,
  parameter  int DIV = 5,
  localparam int RW  = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [W-1:0]  req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [W-1:0]  req1_data,
  output logic          req1_ready,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_id,
  output logic          res_div,
  output logic [RW-1:0] res_rem
);

  localparam int          CW    = $clog2(W);
  localparam logic [RW:0] DIV_T = (RW+1)'(DIV);
  localparam logic [CW-1:0] LAST = CW'(W-1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  sh;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rem;
  logic          id;
  logic          rr_ptr;

  logic          gnt_id;
  logic          accept;
  logic [RW:0]   t;
  logic [RW:0]   t_red;

  // Grant: a lone valid wins outright; a tie goes to rr_ptr.
  always_comb begin
    gnt_id     = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    req0_ready = !rst && (state == IDLE) && req0_valid && !gnt_id;
    req1_ready = !rst && (state == IDLE) && req1_valid &&  gnt_id;
    accept     = req0_ready || req1_ready;
  end

  // Remainder recurrence: rem < DIV so t = 2*rem + b < 2*DIV, hence one
  // conditional subtract brings it back into range and RW+1 bits suffice.
  always_comb begin
    t     = {rem, sh[W-1]};
    t_red = (t >= DIV_T) ? (t - DIV_T) : t;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)       state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST)  state_nxt = DONE;
      DONE:    if (res_ready)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh     <= '0;
      cnt    <= '0;
      rem    <= '0;
      id     <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sh     <= gnt_id ? req1_data : req0_data;
          id     <= gnt_id;
          rem    <= '0;
          cnt    <= '0;
          rr_ptr <= !gnt_id;
        end
        SHIFT: begin
          rem <= t_red[RW-1:0];
          sh  <= {sh[W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result fields are gated by DONE so nothing leaks out mid-computation;
  // rem/id are frozen in DONE, which keeps them stable under backpressure.
  always_comb begin
    res_valid = (state == DONE);
    res_id    = res_valid && id;
    res_rem   = res_valid ? rem : '0;
    res_div   = res_valid && (rem == '0);
  end

endmodule
